// File: rtl/checked_mode_pkg.sv
// Shared state and command definitions for the checked mode controller.
// Decoded command ops give the FSM a width-independent view of cmd.
package checked_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4,
        ST_LOCKED = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ARM   = 3'd1,
        OP_GO    = 3'd2,
        OP_STOP  = 3'd3,
        OP_CLEAR = 3'd4,
        OP_BAD   = 3'd5
    } op_e;

    localparam int unsigned CMD_NOP   = 0;
    localparam int unsigned CMD_ARM   = 1;
    localparam int unsigned CMD_GO    = 2;
    localparam int unsigned CMD_STOP  = 3;
    localparam int unsigned CMD_CLEAR = 4;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts cycles spent in a state, flags the last one.
// tc is high in the cycle the count equals the supplied last value.
module dwell_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc = (count_q == last);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !tc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/checked_mode_fsm.sv
// Checked mode controller: command-driven FSM with arm timeout, run limit,
// fault counting and a sticky lock after repeated faults.
module checked_mode_fsm
    import checked_mode_pkg::*;
#(
    parameter int          CMD_W       = 4,
    parameter int          OUT_W       = 8,
    parameter int          ARM_TIMEOUT = 15,
    parameter int          RUN_MAX     = 31,
    parameter int          MAX_FAULTS  = 3,
    parameter logic [OUT_W-1:0] OUT_IDLE   = 'h55,
    parameter logic [OUT_W-1:0] OUT_ARMED  = 'hAA,
    parameter logic [OUT_W-1:0] OUT_ACTIVE = 'hF0,
    parameter logic [OUT_W-1:0] OUT_DONE   = 'h0F,
    parameter logic [OUT_W-1:0] OUT_FAULT  = 'hFF,
    parameter logic [OUT_W-1:0] OUT_LOCKED = 'h00,
    localparam int FC_W    = $clog2(MAX_FAULTS + 1),
    localparam int CNT_MAX = (ARM_TIMEOUT > RUN_MAX) ? ARM_TIMEOUT : RUN_MAX,
    localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd,
    output logic             cmd_ready,
    output logic [OUT_W-1:0] state_output,
    output logic [2:0]       state_code,
    output logic             fault,
    output logic [FC_W-1:0]  fault_count,
    output logic             locked
);

    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_MAX - 1);
    localparam logic [FC_W-1:0]  FC_SAT   = FC_W'(MAX_FAULTS);

    state_e          state_q;
    state_e          state_d;
    logic [FC_W-1:0] fc_q;
    logic [FC_W-1:0] fc_d;
    op_e             op;
    logic            dwell_clear;
    logic            dwell_en;
    logic            dwell_tc;
    logic [CNT_W-1:0] dwell_last;

    // Unaccepted strobes collapse to NOP so the FSM sees one op per cycle.
    always_comb begin
        op = OP_NOP;
        if (cmd_valid && cmd_ready) begin
            if (cmd == CMD_W'(CMD_NOP)) begin
                op = OP_NOP;
            end else if (cmd == CMD_W'(CMD_ARM)) begin
                op = OP_ARM;
            end else if (cmd == CMD_W'(CMD_GO)) begin
                op = OP_GO;
            end else if (cmd == CMD_W'(CMD_STOP)) begin
                op = OP_STOP;
            end else if (cmd == CMD_W'(CMD_CLEAR)) begin
                op = OP_CLEAR;
            end else begin
                op = OP_BAD;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (op == OP_ARM) begin
                    state_d = ST_ARMED;
                end else if (op != OP_NOP) begin
                    state_d = ST_FAULT;
                end
            end
            ST_ARMED: begin
                if (op == OP_GO) begin
                    state_d = ST_ACTIVE;
                end else if (op == OP_STOP) begin
                    state_d = ST_IDLE;
                end else if (op != OP_NOP) begin
                    state_d = ST_FAULT;
                end else if (dwell_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (op == OP_STOP) begin
                    state_d = ST_DONE;
                end else if (op != OP_NOP) begin
                    state_d = ST_FAULT;
                end else if (dwell_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (op == OP_CLEAR) begin
                    state_d = ST_IDLE;
                end else if (op != OP_NOP) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = (fc_q == FC_SAT) ? ST_LOCKED : ST_IDLE;
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // FAULT never follows itself, so any transition into it is an entry.
    always_comb begin
        fc_d = fc_q;
        if (state_d == ST_FAULT && state_q != ST_FAULT && fc_q != FC_SAT) begin
            fc_d = fc_q + FC_W'(1);
        end
    end

    assign dwell_clear = (state_d != state_q);
    assign dwell_en    = (state_q == ST_ARMED) || (state_q == ST_ACTIVE);
    assign dwell_last  = (state_q == ST_ACTIVE) ? RUN_LAST : ARM_LAST;

    dwell_counter #(
        .W(CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (dwell_clear),
        .enable (dwell_en),
        .last   (dwell_last),
        .tc     (dwell_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_output = OUT_FAULT;
        cmd_ready    = 1'b0;
        fault        = 1'b0;
        locked       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_output = OUT_IDLE;
                cmd_ready    = 1'b1;
            end
            ST_ARMED: begin
                state_output = OUT_ARMED;
                cmd_ready    = 1'b1;
            end
            ST_ACTIVE: begin
                state_output = OUT_ACTIVE;
                cmd_ready    = 1'b1;
            end
            ST_DONE: begin
                state_output = OUT_DONE;
                cmd_ready    = 1'b1;
            end
            ST_FAULT: begin
                state_output = OUT_FAULT;
                fault        = 1'b1;
            end
            ST_LOCKED: begin
                state_output = OUT_LOCKED;
                locked       = 1'b1;
            end
            default: begin
                state_output = OUT_FAULT;
            end
        endcase
    end

    assign state_code  = state_q;
    assign fault_count = fc_q;

endmodule

// File: tb/tb_checked_mode_fsm.sv
// Directed vector bench for checked_mode_fsm with default parameters.
module tb_checked_mode_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_ready;
    logic [7:0] state_output;
    logic [2:0] state_code;
    logic       fault;
    logic [1:0] fault_count;
    logic       locked;

    int n_cmp = 0;
    int n_bad = 0;

    checked_mode_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_ready    (cmd_ready),
        .state_output (state_output),
        .state_code   (state_code),
        .fault        (fault),
        .fault_count  (fault_count),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] c;
        logic [2:0] st;
        logic [1:0] fc;
    } vec_t;

    function automatic logic [7:0] out_of(input logic [2:0] s);
        case (s)
            3'd0: return 8'h55;
            3'd1: return 8'hAA;
            3'd2: return 8'hF0;
            3'd3: return 8'h0F;
            3'd4: return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [2:0] st,
                       input logic [1:0] fc);
        logic [7:0] eo;
        logic       er;
        eo = out_of(st);
        er = (st <= 3'd3);
        n_cmp++;
        if (state_code !== st || state_output !== eo ||
            fault_count !== fc || cmd_ready !== er ||
            fault !== (st == 3'd4) || locked !== (st == 3'd5)) begin
            n_bad++;
            $display("FAIL %s: got st=%0d out=%h fc=%0d rdy=%b flt=%b lck=%b want st=%0d out=%h fc=%0d rdy=%b",
                     name, state_code, state_output, fault_count,
                     cmd_ready, fault, locked, st, eo, fc, er);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        cmd_valid = v;
        cmd = c;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back('{1'b1, 4'd1, 3'd1, 2'd0});
        vt.push_back('{1'b1, 4'd2, 3'd2, 2'd0});
        for (int i = 0; i < 5; i++) vt.push_back('{1'b1, 4'd0, 3'd2, 2'd0});
        vt.push_back('{1'b1, 4'd3, 3'd3, 2'd0});
        vt.push_back('{1'b1, 4'd4, 3'd0, 2'd0});
        vt.push_back('{1'b0, 4'd2, 3'd0, 2'd0});
        vt.push_back('{1'b1, 4'd2, 3'd4, 2'd1});
        vt.push_back('{1'b1, 4'd0, 3'd0, 2'd1});
        vt.push_back('{1'b1, 4'd2, 3'd4, 2'd2});
        vt.push_back('{1'b1, 4'd0, 3'd0, 2'd2});
        vt.push_back('{1'b1, 4'd2, 3'd4, 2'd3});
        vt.push_back('{1'b1, 4'd0, 3'd5, 2'd3});
        vt.push_back('{1'b1, 4'd1, 3'd5, 2'd3});
        vt.push_back('{1'b1, 4'd4, 3'd5, 2'd3});

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 3'd0, 2'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            step(vt[i].v, vt[i].c);
            chk($sformatf("vec%0d", i), vt[i].st, vt[i].fc);
        end

        // asynchronous reset out of LOCKED, no clock edge needed
        #2 rst = 1'b1;
        #1 chk("async_rst", 3'd0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        chk("to_active", 3'd2, 2'd0);
        step(1'b1, 4'hB);
        chk("bad_cmd", 3'd4, 2'd1);
        step(1'b1, 4'd0);
        chk("fault_1cyc", 3'd0, 2'd1);

        step(1'b1, 4'd1);
        repeat (14) step(1'b1, 4'd0);
        chk("arm_14", 3'd1, 2'd1);
        step(1'b1, 4'd0);
        chk("arm_timeout", 3'd0, 2'd1);

        step(1'b1, 4'd1);
        repeat (14) step(1'b1, 4'd0);
        step(1'b1, 4'd2);
        chk("go_at_timeout", 3'd2, 2'd1);

        repeat (30) step(1'b1, 4'd0);
        chk("run_30", 3'd2, 2'd1);
        step(1'b1, 4'd0);
        chk("run_max", 3'd3, 2'd1);
        step(1'b1, 4'd4);
        chk("clear", 3'd0, 2'd1);

        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        repeat (30) step(1'b1, 4'd0);
        step(1'b1, 4'd3);
        chk("stop_at_max", 3'd3, 2'd1);
        step(1'b1, 4'd0);
        chk("done_hold", 3'd3, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
